// File: rtl/pci_pkg.sv
// ---------------------------------------------------------------------------
// pci_pkg
// Shared definitions for the PCI initiator slice.
//   - PCI command codes driven on CBE during the address phase
//   - initiator FSM state encoding (also exported on the debug state port)
//   - default maximum burst length
//   - pci_cmd(): maps the latched direction bit to its bus command
// The ABORT state value is always defined here. It is only reachable when
// the design is built with PCI_INITIATOR_ABORT_EN.
// ---------------------------------------------------------------------------
package pci_pkg;

    localparam logic [3:0] PCI_CMD_MEM_READ  = 4'h6;
    localparam logic [3:0] PCI_CMD_MEM_WRITE = 4'h7;

    localparam int PCI_MAX_BURST = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_ABORT   = 3'd3,
        ST_RELEASE = 3'd4
    } pci_state_e;

    function automatic logic [3:0] pci_cmd(input logic write);
        return write ? PCI_CMD_MEM_WRITE : PCI_CMD_MEM_READ;
    endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// ---------------------------------------------------------------------------
// pci_initiator_if
// PCI bus signals between the initiator and the target it drives.
//   Frame   FRAME#, active-low, driven by the initiator
//   Irdy    IRDY#, active-low, driven by the initiator
//   CBE     command (address phase) / byte enables (data phases)
//   AD_out  AddressData value driven by the initiator
//   AD_oe   enable for AD_out; the chip top builds the inout from these
//   AD_in   AddressData as seen on the bus
//   Devsel  DEVSEL#, active-low, driven by the target
//   Trdy    TRDY#, active-low, driven by the target
//
// Handshake: a data phase transfers on a rising edge where Irdy and Trdy are
// both sampled low. Either side may hold its ready high to insert wait
// states. While a phase is pending, the initiator keeps its drive values
// stable.
// ---------------------------------------------------------------------------
interface pci_initiator_if;

    logic        Frame;
    logic        Irdy;
    logic [3:0]  CBE;
    logic [31:0] AD_out;
    logic        AD_oe;
    logic [31:0] AD_in;
    logic        Devsel;
    logic        Trdy;

    modport master (
        output Frame, Irdy, CBE, AD_out, AD_oe,
        input  AD_in, Devsel, Trdy
    );

    modport slave (
        input  Frame, Irdy, CBE, AD_out, AD_oe,
        output AD_in, Devsel, Trdy
    );

endinterface

// File: rtl/pci_initiator_abort_timer.sv
// ---------------------------------------------------------------------------
// pci_abort_timer
// Counts cycles in which no target has claimed the transaction.
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        return the count to zero (held while not in a data phase)
//   en_i         count this cycle
//   expired_o    high when this cycle's increment reaches TIMEOUT
// The count is 0 in the first data cycle. When expired_o is high, the
// initiator leaves DATA at the same edge where the count would reach TIMEOUT.
// ---------------------------------------------------------------------------
module pci_abort_timer #(
    parameter int TIMEOUT = 5,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pci_initiator.sv
// ---------------------------------------------------------------------------
// pci_initiator
// PCI bus master. It turns a local single or burst request into one address
// phase followed by 1..MAX_BURST data phases (memory read or memory write).
//
// Ports
//   clk, rst_n     bus clock, asynchronous active-low reset
//   req_i          start a transaction (sampled only in IDLE)
//   req_write_i    1 = memory write, 0 = memory read
//   req_addr_i     address for the address phase
//   req_len_i      data phases; 0 counts as 1, values above MAX_BURST clamp
//   req_be_i       byte enables driven in every data phase
//   wr_data_i      current write word, held until wr_adv_o
//   wr_adv_o       the current write word transfers at this edge
//   rd_data_o      captured read word, qualified by rd_valid_o
//   rd_valid_o     one pulse per completed read phase (registered)
//   busy_o         transaction in progress (state not IDLE)
//   done_o         pulse in RELEASE after normal completion
//   abort_o        pulse in RELEASE after master abort
//   state_o        current FSM state (debug)
//   bus            PCI bus signals, master side
//
// Build option PCI_INITIATOR_ABORT_EN: when defined, an abort timer runs.
// If DEVSEL# is not seen for ABORT_TIMEOUT data cycles, the initiator goes
// through ABORT and releases the bus. When undefined, the initiator waits
// indefinitely and abort_o is always 0.
// ---------------------------------------------------------------------------
module pci_initiator
    import pci_pkg::*;
#(
    parameter int MAX_BURST     = PCI_MAX_BURST,
    parameter int LEN_W         = 3,
    parameter int ABORT_TIMEOUT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             req_write_i,
    input  logic [31:0]      req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [3:0]       req_be_i,
    input  logic [31:0]      wr_data_i,
    output logic             wr_adv_o,
    output logic [31:0]      rd_data_o,
    output logic             rd_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             abort_o,
    output pci_state_e       state_o,
    pci_initiator_if.master  bus
);

    pci_state_e       state_q, state_d;
    logic             write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    logic             frame;
    logic             irdy;
    logic             ad_oe;
    logic [31:0]      ad_out;
    logic [3:0]       cbe;
    logic             wr_adv;
    logic [LEN_W-1:0] len_clamped;

    always_comb begin
        len_clamped = req_len_i;
        if (req_len_i == '0) begin
            len_clamped = LEN_W'(1);
        end else if (req_len_i > LEN_W'(MAX_BURST)) begin
            len_clamped = LEN_W'(MAX_BURST);
        end
    end

`ifdef PCI_INITIATOR_ABORT_EN
    // After DEVSEL# is sampled low once, the target owns the cycle. Later
    // DEVSEL# activity no longer feeds the timer.
    logic devsel_seen_q, devsel_seen_d;
    logic in_data;
    logic timer_en;
    logic timeout_hit;

    always_comb begin
        in_data       = (state_q == ST_DATA);
        devsel_seen_d = in_data && (devsel_seen_q || !bus.Devsel);
        timer_en      = in_data && !devsel_seen_q && bus.Devsel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            devsel_seen_q <= 1'b0;
        end else begin
            devsel_seen_q <= devsel_seen_d;
        end
    end

    pci_abort_timer #(
        .TIMEOUT (ABORT_TIMEOUT)
    ) u_abort_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!in_data),
        .en_i      (timer_en),
        .expired_o (timeout_hit)
    );
`else
    logic unused_devsel;
    assign unused_devsel = bus.Devsel | (ABORT_TIMEOUT == 0);
`endif

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        be_d       = be_q;
        remain_d   = remain_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        frame      = 1'b1;
        irdy       = 1'b1;
        ad_oe      = 1'b0;
        ad_out     = '0;
        cbe        = '0;
        wr_adv     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    write_d  = req_write_i;
                    addr_d   = req_addr_i;
                    be_d     = req_be_i;
                    remain_d = len_clamped;
                    state_d  = ST_ADDR;
                end
            end

            ST_ADDR: begin
                frame   = 1'b0;
                ad_out  = addr_q;
                ad_oe   = 1'b1;
                cbe     = pci_cmd(write_q);
                state_d = ST_DATA;
            end

            ST_DATA: begin
                irdy  = 1'b0;
                cbe   = be_q;
                // FRAME# goes high while the last phase is still pending.
                frame = (remain_q == LEN_W'(1));
                // Reads keep AD undriven for the whole DATA state. The first
                // cycle is the bus turnaround.
                if (write_q) begin
                    ad_out = wr_data_i;
                    ad_oe  = 1'b1;
                end
                // IRDY# is always low in DATA, so TRDY# alone decides completion.
                if (!bus.Trdy) begin
                    if (write_q) begin
                        wr_adv = 1'b1;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = bus.AD_in;
                    end
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = ST_RELEASE;
                        done_d  = 1'b1;
                    end
                end
`ifdef PCI_INITIATOR_ABORT_EN
                else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
`endif
            end

`ifdef PCI_INITIATOR_ABORT_EN
            ST_ABORT: begin
                frame   = 1'b1;
                irdy    = 1'b0;
                cbe     = be_q;
                abort_d = 1'b1;
                state_d = ST_RELEASE;
            end
`endif

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            remain_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            remain_q   <= remain_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.Frame  = frame;
    assign bus.Irdy   = irdy;
    assign bus.CBE    = cbe;
    assign bus.AD_out = ad_out;
    assign bus.AD_oe  = ad_oe;

    assign wr_adv_o   = wr_adv;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign abort_o    = abort_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pci_initiator.sv
// ---------------------------------------------------------------------------
// tb_pci_initiator
// Drives pci_initiator through directed and randomized transactions.
// Outputs are compared cycle by cycle against expectations built from the
// bus protocol rules:
//   - address phase, then data cycles (phases plus wait states)
//   - FRAME# high on the last pending phase
//   - RELEASE with done, then IDLE
// Read words go through an expected-value queue. Abort behaviour is covered
// when PCI_INITIATOR_ABORT_EN is defined.
// ---------------------------------------------------------------------------
module tb_pci_initiator;
    import pci_pkg::*;

    localparam int MAXB    = 4;
    localparam int TIMEOUT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_len;
    logic [3:0]  req_be;
    logic [31:0] wr_data;
    logic        wr_adv;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        abort;
    pci_state_e  state;

    pci_initiator_if bus_if ();

    pci_initiator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .req_be_i    (req_be),
        .wr_data_i   (wr_data),
        .wr_adv_o    (wr_adv),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .busy_o      (busy),
        .done_o      (done),
        .abort_o     (abort),
        .state_o     (state),
        .bus         (bus_if)
    );

    // clock
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wwords[4];
    logic [31:0] rwords[4];
    int          wait_n[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input int raw);
        if (raw == 0) return 1;
        if (raw > MAXB) return MAXB;
        return raw;
    endfunction

    // Moves to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // The request inputs are noise while busy. They must not be latched and
    // must not start a new transaction.
    task automatic scramble_req();
        req       = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_len   = 3'($urandom_range(0, 7));
        req_be    = 4'($urandom);
    endtask

    task automatic check_rd(input bit pend);
        logic [31:0] e;
        check("rd_valid", 32'(rd_valid), 32'(pend));
        if (pend) begin
            e = exp_q.pop_front();
            check("rd_data", rd_data, e);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_frame"}, 32'(bus_if.Frame), 32'd1);
        check({tag, "_irdy"},  32'(bus_if.Irdy),  32'd1);
        check({tag, "_oe"},    32'(bus_if.AD_oe), 32'd0);
        check({tag, "_cbe"},   32'(bus_if.CBE),   32'd0);
        check({tag, "_busy"},  32'(busy),         32'd0);
        check({tag, "_done"},  32'(done),         32'd0);
        check({tag, "_abort"}, 32'(abort),        32'd0);
        check({tag, "_state"}, 32'(state),        32'(ST_IDLE));
    endtask

    // Call from an IDLE cycle at +1 after the edge. Uses wwords/rwords/wait_n.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [2:0] len_raw,
                           input logic [3:0] be);
        int   len;
        bit   rd_pend;
        bit   last;
        logic [3:0] cmd;
        len = eff_len(int'(len_raw));
        cmd = wr ? 4'h7 : 4'h6;
        // Read targets never complete in the turnaround cycle.
        if (!wr && wait_n[0] < 1) wait_n[0] = 1;

        req = 1'b1; req_write = wr; req_addr = addr; req_len = len_raw; req_be = be;
        bus_if.Trdy = 1'b1; bus_if.Devsel = 1'b1;
        settle();
        check("pre_busy", 32'(busy), 32'd0);

        // address phase
        step(); scramble_req(); settle();
        check("addr_frame", 32'(bus_if.Frame), 32'd0);
        check("addr_irdy",  32'(bus_if.Irdy),  32'd1);
        check("addr_oe",    32'(bus_if.AD_oe), 32'd1);
        check("addr_ad",    bus_if.AD_out,     addr);
        check("addr_cbe",   32'(bus_if.CBE),   32'(cmd));
        check("addr_busy",  32'(busy),         32'd1);
        rd_pend = 1'b0;

        // data cycles
        for (int p = 0; p < len; p++) begin
            for (int w = 0; w <= wait_n[p]; w++) begin
                step(); scramble_req();
                last          = (w == wait_n[p]);
                bus_if.Trdy   = !last;
                bus_if.Devsel = (p == 0 && w == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                bus_if.AD_in  = last ? rwords[p] : $urandom;
                wr_data       = wwords[p];
                settle();
                check_rd(rd_pend);
                check("data_frame", 32'(bus_if.Frame), 32'(len - p == 1));
                check("data_irdy",  32'(bus_if.Irdy),  32'd0);
                check("data_oe",    32'(bus_if.AD_oe), 32'(wr));
                check("data_cbe",   32'(bus_if.CBE),   32'(be));
                if (wr) check("data_ad", bus_if.AD_out, wwords[p]);
                check("wr_adv",     32'(wr_adv),       32'(wr && last));
                check("data_done",  32'(done),         32'd0);
                check("data_abort", 32'(abort),        32'd0);
                check("data_busy",  32'(busy),         32'd1);
                rd_pend = !wr && last;
                if (rd_pend) exp_q.push_back(rwords[p]);
            end
        end

        // release
        step(); scramble_req();
        bus_if.Trdy = 1'b1; bus_if.Devsel = 1'b1;
        settle();
        check_rd(rd_pend);
        check("rel_frame",  32'(bus_if.Frame), 32'd1);
        check("rel_irdy",   32'(bus_if.Irdy),  32'd1);
        check("rel_oe",     32'(bus_if.AD_oe), 32'd0);
        check("rel_done",   32'(done),         32'd1);
        check("rel_abort",  32'(abort),        32'd0);
        check("rel_busy",   32'(busy),         32'd1);
        check("rel_wr_adv", 32'(wr_adv),       32'd0);

        step(); req = 1'b0; settle();
        check_rd(1'b0);
        check_idle("idle");
    endtask

`ifdef PCI_INITIATOR_ABORT_EN
    task automatic run_abort(input bit wr);
        req = 1'b1; req_write = wr; req_addr = $urandom; req_len = 3'd2; req_be = 4'hA;
        bus_if.Trdy = 1'b1; bus_if.Devsel = 1'b1;
        step(); req = 1'b0; settle();
        check("ab_addr_frame", 32'(bus_if.Frame), 32'd0);
        for (int c = 0; c < TIMEOUT; c++) begin
            step(); settle();
            check("ab_data_irdy", 32'(bus_if.Irdy), 32'd0);
            check("ab_data_busy", 32'(busy),        32'd1);
            check("ab_wr_adv",    32'(wr_adv),      32'd0);
            check("ab_rd_valid",  32'(rd_valid),    32'd0);
        end
        step(); settle();
        check("ab_frame",    32'(bus_if.Frame), 32'd1);
        check("ab_irdy",     32'(bus_if.Irdy),  32'd0);
        check("ab_wr_adv",   32'(wr_adv),       32'd0);
        check("ab_rd_valid", 32'(rd_valid),     32'd0);
        check("ab_done",     32'(done),         32'd0);
        step(); settle();
        check("abrel_irdy",  32'(bus_if.Irdy),  32'd1);
        check("abrel_frame", 32'(bus_if.Frame), 32'd1);
        check("abrel_oe",    32'(bus_if.AD_oe), 32'd0);
        check("abrel_abort", 32'(abort),        32'd1);
        check("abrel_done",  32'(done),         32'd0);
        check("abrel_rdv",   32'(rd_valid),     32'd0);
        step(); settle();
        check_idle("ab_idle");
    endtask
`endif

    initial begin
        // reset block
        rst_n = 1'b0;
        req = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_be = '0; wr_data = '0;
        bus_if.AD_in = '0; bus_if.Trdy = 1'b1; bus_if.Devsel = 1'b1;
        #1;
        check_idle("rst");
        check("rst_ad",     bus_if.AD_out,  32'd0);
        check("rst_rdv",    32'(rd_valid),  32'd0);
        check("rst_rddata", rd_data,        32'd0);
        check("rst_wradv",  32'(wr_adv),    32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // single write, addr 21, len 1
        wwords = '{32'h1, 32'h0, 32'h0, 32'h0};
        wait_n = '{0, 0, 0, 0};
        run_txn(1'b1, 32'd21, 3'd1, 4'hF);

        // zero-wait burst write 1,2,3
        wwords = '{32'h1, 32'h2, 32'h3, 32'h0};
        run_txn(1'b1, 32'h100, 3'd3, 4'h3);

        // burst read 1,2,3 with TRDY# from the second data cycle
        rwords = '{32'h1, 32'h2, 32'h3, 32'h0};
        wait_n = '{1, 0, 0, 0};
        run_txn(1'b0, 32'd21, 3'd3, 4'h0);

        // write len 2 with two wait states before each phase
        wwords = '{32'hCAFE0001, 32'hCAFE0002, 32'h0, 32'h0};
        wait_n = '{2, 2, 0, 0};
        run_txn(1'b1, 32'h2000, 3'd2, 4'h5);

        // length boundaries: 0 runs one phase, 7 clamps to MAXB
        wait_n = '{0, 0, 0, 0};
        wwords = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_txn(1'b1, 32'h3000, 3'd0, 4'hF);
        run_txn(1'b1, 32'h3004, 3'd7, 4'hF);
        rwords = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        run_txn(1'b0, 32'h3008, 3'd5, 4'hC);

        // randomized transactions
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 4; i++) begin
                wwords[i] = $urandom;
                rwords[i] = $urandom;
                wait_n[i] = $urandom_range(0, 3);
            end
            run_txn(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), 4'($urandom));
        end

`ifdef PCI_INITIATOR_ABORT_EN
        run_abort(1'b1);
        run_abort(1'b0);
`endif

        // reset in the middle of a burst, after the first phase
        req = 1'b1; req_write = 1'b1; req_addr = 32'h4000; req_len = 3'd4; req_be = 4'hF;
        bus_if.Trdy = 1'b0; bus_if.Devsel = 1'b0; wr_data = 32'h55;
        step(); req = 1'b0;              // address phase
        step();                          // first data cycle, completes at next edge
        step(); settle();                // second data cycle
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        check("midrst_ad",    bus_if.AD_out, 32'd0);
        check("midrst_wradv", 32'(wr_adv),   32'd0);
        step();
        rst_n = 1'b1;
        bus_if.Trdy = 1'b1; bus_if.Devsel = 1'b1;
        step(); settle();
        check_idle("postrst");
        check("postrst_rdv", 32'(rd_valid), 32'd0);

        // a fresh transaction after reset starts at the address phase
        wwords = '{32'h77, 32'h88, 32'h0, 32'h0};
        wait_n = '{0, 1, 0, 0};
        step();
        run_txn(1'b1, 32'h5000, 3'd2, 4'h9);

        if (exp_q.size() != 0) begin
            check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
